// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO; divider built only when MD_DIV_EN is defined
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mreg;
    logic               neg_res;
    logic               is_signed;
    logic               accept;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_fix;

    assign is_signed = ~op[0];
    assign mag1      = (is_signed && in1[WIDTH-1]) ? -in1 : in1;
    assign mag2      = (is_signed && in2[WIDTH-1]) ? -in2 : in2;
    // Shift-add step: add multiplicand to the upper half, keep the carry, shift right.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mreg : {WIDTH{1'b0}})};
    assign prod_fix  = neg_res ? -acc : acc;
    assign busy      = (state != IDLE);

`ifdef MD_DIV_EN
    logic             is_div;
    logic             div0;
    logic             neg_rem;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH+1:0] trial;

    assign accept    = (state == IDLE) && start;
    assign rem_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
    // Trial subtraction one bit wider than the remainder so the MSB is the borrow.
    assign trial     = {rem, acc[WIDTH-1]} - {2'b00, mreg};
`else
    assign accept    = (state == IDLE) && start && !op[1];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (count == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            acc     <= '0;
            mreg    <= '0;
            neg_res <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
`ifdef MD_DIV_EN
            is_div  <= 1'b0;
            div0    <= 1'b0;
            neg_rem <= 1'b0;
            rem     <= '0;
`endif
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (accept) begin
                        count   <= '0;
                        neg_res <= is_signed && (in1[WIDTH-1] ^ in2[WIDTH-1]);
`ifdef MD_DIV_EN
                        neg_rem <= is_signed && in1[WIDTH-1];
                        is_div  <= op[1];
                        div0    <= (in2 == '0);
                        rem     <= '0;
                        if (op[1]) begin
                            mreg <= mag2;
                            acc  <= {{WIDTH{1'b0}}, mag1};
                        end else
`endif
                        begin
                            mreg <= mag1;
                            acc  <= {{WIDTH{1'b0}}, mag2};
                        end
                    end
                end
                CALC: begin
                    count <= count + 1'b1;
`ifdef MD_DIV_EN
                    if (is_div) begin
                        acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~trial[WIDTH+1]};
                        rem <= trial[WIDTH+1] ? rem_shift : trial[WIDTH:0];
                    end else
`endif
                    begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                FIX: begin
`ifdef MD_DIV_EN
                    // Divide by zero leaves rem = |in1|; restoring its sign gives back in1.
                    if (is_div) begin
                        lo <= div0 ? {WIDTH{1'b1}}
                                   : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
                        hi <= neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    end else
`endif
                    begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit against an arithmetic reference model
module tb_mul_div_unit;

`ifdef MD_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] in1, in2, wdata;
    logic        hi_we, lo_we;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb_q[$];
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns {hi, lo} straight from the MIPS arithmetic rules.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              qa, qb;
        case (o)
            2'b00: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return 64'(sa * sb);
            end
            2'b01: begin
                ua = 64'(a);
                ub = 64'(b);
                return ua * ub;
            end
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                qa = $signed(a);
                qb = $signed(b);
                return {32'(qa % qb), 32'(qa / qb)};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset && done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                check("hilo_result", {hi, lo}, sb_q.pop_front());
                check("busy_in_done", 64'(busy), 64'd0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 64'(busy), 64'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit mt, input bit disturb);
        bit          taken = DIV_EN || !o[1];
        bit          busy_ok = 1'b1;
        int          lat = 0;
        logic [63:0] res;
        wait_idle();
        start = 1'b1; op = o; in1 = a; in2 = b;
        if (mt) begin
            hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
            exp_hi = wdata; exp_lo = wdata;
        end
        res = ref_model(o, a, b);
        if (taken) sb_q.push_back(res);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        in1 = $urandom; in2 = $urandom; op = 2'($urandom);
        check("done_single", 64'(done), 64'd0);
        check("hilo_after_accept", {hi, lo}, {exp_hi, exp_lo});
        if (!taken) begin
            check("ignored_busy", 64'(busy), 64'd0);
            @(negedge clk);
            check("ignored_done", 64'(done), 64'd0);
            return;
        end
        while (!done && lat < 100) begin
            if (disturb && lat == 4) begin
                start = 1'b1; hi_we = 1'b1; wdata = ~exp_hi; op = 2'b01; in1 = 32'd7; in2 = 32'd9;
            end else begin
                start = 1'b0; hi_we = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (lat <= 32 && !busy) busy_ok = 1'b0;
            if (disturb && lat == 5) check("hi_hold_busy", 64'(hi), 64'(exp_hi));
        end
        start = 1'b0; hi_we = 1'b0;
        check("latency", 64'(lat), 64'd33);
        check("busy_window", 64'(busy_ok), 64'd1);
        exp_hi = res[63:32];
        exp_lo = res[31:0];
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b0; start = 1'b0; op = 2'b00; in1 = '0; in2 = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);

        hi_we = 1'b1; wdata = 32'hA5A5_0001;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
        @(negedge clk);
        lo_we = 1'b0;
        check("mthi_mtlo", {hi, lo}, {32'hA5A5_0001, 32'h0BAD_F00D});
        exp_hi = 32'hA5A5_0001; exp_lo = 32'h0BAD_F00D;

        run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0);
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        run_op(2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFFFFF9, 32'd0, 1'b0, 1'b0);
        run_op(2'b00, 32'h80000000, 32'h80000000, 1'b1, 1'b0);
        run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'h0;
                1:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
        end

        wait_idle();
        start = 1'b1; op = 2'b00; in1 = $urandom; in2 = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_hilo", {hi, lo}, 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("after_reset_idle", 64'(busy), 64'd0);
        check("after_reset_hilo", {hi, lo}, 64'd0);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the pipelined MIPS datapath. It sits beside the execute-stage ALU and takes the MULT/MULTU/DIV/DIVU operations off it. Results go into architectural HI/LO registers, which feed MFHI/MFLO. While busy it asserts `busy` so the hazard unit can stall any HI/LO-dependent instruction.

## Interface
- `WIDTH`, 32, operand and HI/LO width; the iteration count equals `WIDTH`.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request a new operation, sampled on a rising edge.
- `op` input 2: operation select, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `in1` input WIDTH: multiplicand or dividend (rs).
- `in2` input WIDTH: multiplier or divisor (rt).
- `hi_we` input 1: MTHI write enable.
- `lo_we` input 1: MTLO write enable.
- `wdata` input WIDTH: MTHI/MTLO data.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse when HI/LO have been updated by an operation.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- **States:**
  - IDLE. `busy`=0.
  - CALC: 32 iterations. `busy`=1.
  - FIX: 1 cycle. `busy`=1.
- **IDLE:** on `start`=1, the unit:
  - latches the magnitudes of `in1`/`in2` (magnitudes are taken for signed ops only);
  - latches the result-sign flags;
  - clears the iteration counter;
  - moves to CALC.
- **CALC multiply:** shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
- **CALC divide:** restoring, one quotient bit per cycle. The remainder register is 33 bits so the trial subtraction produces a borrow.
- **Counter:** when it reaches 31, the next state is FIX.
- **FIX, multiply:** negate the 64-bit product if exactly one operand was negative (signed op only). HI = upper 32 bits, LO = lower 32 bits.
- **FIX, divide:**
  - LO = quotient, truncated toward zero.
  - HI = remainder, carrying the sign of the dividend.
  - Quotient is negated when the operand signs differ.
- FIX pulses `done`, then returns to IDLE.
- **Divide by zero:** LO = 32'hFFFFFFFF, HI = original `in1`, in both signed and unsigned modes. There is no exception.
- **DIV 32'h80000000 / 32'hFFFFFFFF:** LO = 32'h80000000, HI = 0.
- **`start` while busy:** ignored. The request is not queued.
- **`hi_we`/`lo_we`:**
  - In IDLE: written at the edge.
  - While busy: ignored.
  - With `start` in the same IDLE cycle: both the write and the start take effect, and the operation result overwrites HI/LO at FIX.
- **Operand stability:** `in1`/`in2`/`op` are don't-care after the accept edge.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- `start` is accepted at edge k; `busy`=1 from after edge k through edge k+33.
- CALC occupies edges k+1..k+32. FIX occurs at edge k+33.
- `hi`/`lo` are updated at edge k+33.
- `done`=1 for exactly the cycle after edge k+33; `busy` is already 0 in that cycle.
- Back-to-back issue: a new `start` can be accepted at edge k+34 (the `done` cycle), giving a throughput of one operation per 34 cycles.
- **Reset mid-operation:** immediate return to IDLE with all outputs at their reset values. Partial results are discarded.
- `hi`/`lo` are registered outputs and hold stable between updates.

## Configuration
- **`MD_DIV_EN` defined:** DIV/DIVU are implemented as described above.
- **`MD_DIV_EN` undefined:**
  - The divider datapath and the 33-bit remainder register are removed.
  - `start` with `op[1]`=1 is ignored: state stays IDLE, `busy` and `done` stay 0, HI/LO are unchanged.
  - MULT/MULTU behaviour and timing are identical to the `MD_DIV_EN`-defined build.

## Test plan
- Reset check: after reset release, `busy`=0, `done`=0, `hi`=0, `lo`=0.
- MULT, `in1`=32'hFFFFFFFD (-3), `in2`=5 -> after 33 cycles `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFF1; `done` pulses once.
- MULTU, 32'hFFFFFFFF × 32'hFFFFFFFF -> `hi`=32'hFFFFFFFE, `lo`=32'h00000001.
- DIV, -7 / 2 -> `lo`=32'hFFFFFFFD, `hi`=32'hFFFFFFFF.
- DIVU, 100 / 0 -> `lo`=32'hFFFFFFFF, `hi`=32'h00000064.
- Pulse `start` and `hi_we` at edge k+5 while busy -> both ignored, and the original result lands at k+33. Then assert `reset` at cycle 10 of a new MULT -> `busy`=0 and `hi`/`lo`=0 immediately, and no `done` pulse follows.
